protocol_switcher: RTL and testbench
====================================

// Module: protocol_switcher
// PURPOSE
//  Parametrised successor of the protocol output selector. Routes one of N_CH (data, indicator)
//  channel pairs, or the DC level, to the two DAC-bound outputs. Protocol changes are glitch-safe:
//  outputs park at DC for a programmable guard interval before the new channel is connected.
//  Sits between the protocol generators and the DAC output registers.
// PARAMETERS
//  W            14  sample width, two's complement (DAC word)
//  N_CH         5   number of selectable channels, codes 1..N_CH; code 0 = DC
//  SEL_W        3   protocol code width; must satisfy 2**SEL_W > N_CH
//  GUARD_CYCLES 16  DC-park cycles on every protocol change; 0 = immediate switch
//  RAMP_STEP    64  per-cycle step magnitude for the optional ramp-out (macro-gated)
// PORTS
//  clk_i        in   1          system clock
//  rst_i        in   1          synchronous reset, active-high
//  data_i       in   N_CH*W     channel data, channel c at [c*W +: W], c=0..N_CH-1 (code c+1)
//  indicator_i  in   N_CH*W     channel indicator, same packing
//  dc_i         in   W          DC / park level
//  protocol_i   in   SEL_W      requested protocol code
//  output0_o    out  W          registered data output
//  output1_o    out  W          registered indicator output
//  active_o     out  SEL_W      protocol code currently connected
//  busy_o       out  1          1 while in GUARD
//  invalid_o    out  1          1 while active_o > N_CH
// BEHAVIOUR
//  - Single clock clk_i; reset rst_i synchronous, active-high. All outputs registered.
//  - Reset: output0_o=output1_o=0, active_o=0, busy_o=0, invalid_o=0, state=RUN, counter=0.
//  - sel(p): p=0 -> (dc_i, dc_i); 1<=p<=N_CH -> (data ch p-1, indicator ch p-1); p>N_CH -> (0, 0).
//  - RUN: if protocol_i==active_o, outputs <= sel(active_o): latency 1 cycle from inputs.
//    If protocol_i!=active_o at edge k and GUARD_CYCLES>0: target<=protocol_i, cnt<=GUARD_CYCLES-1,
//    state<=GUARD, both outputs <= dc_i at edge k.
//    If GUARD_CYCLES==0: active_o<=protocol_i and outputs<=sel(protocol_i) at edge k; busy_o stays 0.
//  - GUARD: busy_o=1. Each edge: if protocol_i!=target -> target<=protocol_i, cnt<=GUARD_CYCLES-1
//    (guard restarts). Else if cnt==0 -> active_o<=target, state<=RUN, outputs<=sel(target).
//    Else cnt<=cnt-1, outputs<=dc_i. Net: exactly GUARD_CYCLES DC cycles after the last change,
//    new channel visible from edge k+GUARD_CYCLES.
//  - Change back to old active_o during GUARD still completes the guard (no shortcut).
//  - Invalid codes (>N_CH) go through the guard like any code; then outputs 0, invalid_o=1.
//  - rst_i mid-GUARD: abort immediately to reset values; no guard is run for the post-reset code
//    unless protocol_i!=0, which starts a normal guard on the first edge after reset release.
//  - dc_i is tracked live during guard (not latched).
// CONFIGURATION
//  - Macro PROTOCOL_SWITCHER_RAMP_EN.
//    Defined: during GUARD each output moves from its current value toward dc_i by RAMP_STEP per
//    cycle in signed W+1-bit arithmetic; if |dc_i - out| <= RAMP_STEP output <= dc_i (no overshoot).
//    On guard expiry the switch to sel(target) happens even if dc_i was not reached.
//    Not defined: outputs step to dc_i on the first guard edge (behaviour above); RAMP_STEP unused.
// STRUCTURE
//  - protocol_switcher_pkg: state enum {RUN, GUARD}; constant PROTO_DC=0; function ch_index(code).
//  - Sub-module protocol_channel_mux: combinational sel(p) over packed data_i/indicator_i/dc_i.
//  - Top holds FSM, guard counter ($clog2(GUARD_CYCLES+1) bits), target/active regs, outputs.
// TESTING
//  1 Reset, protocol_i=0, dc_i=100 -> outputs 0 during reset, 100/100 one edge after release.
//  2 G=16, active=0, protocol_i 0->3 at edge k, data ch2=500, ind ch2=-7 -> outputs=dc_i for
//    edges k..k+15, busy_o=1; 500/-7 from edge k+16, active_o=3, busy_o=0.
//  3 Mid-guard retarget: 0->2 at k, ->4 at k+5 -> DC until k+20, then ch3 data; active_o=4.
//  4 protocol_i=7 (N_CH=5) -> guard, then outputs 0/0, invalid_o=1; back to 1 clears invalid_o
//    on the edge the guard ends.
//  5 GUARD_CYCLES=0 build: code change at edge k -> new channel at edge k, busy_o never 1.
//  6 RAMP_EN, STEP=64, out=1000, dc_i=0, G=20 -> 936,872,...,40,0 (0 from 16th guard edge),
//    then new channel at edge k+20; also rst_i at guard edge 3 -> all outputs 0 next edge.

Source files
------------

// File: rtl/protocol_switcher_pkg.sv
// rtl/protocol_switcher_pkg.sv - shared types and helpers for the protocol output switcher
package protocol_switcher_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_GUARD = 1'b1
    } state_t;

    localparam int PROTO_DC = 0;

    // Protocol codes 1..N_CH map onto packed channel slots 0..N_CH-1.
    function automatic int ch_index(input int code);
        return code - 1;
    endfunction

endpackage

// File: rtl/protocol_switcher_if.sv
// rtl/protocol_switcher_if.sv - channel inputs and DAC-bound outputs of the protocol switcher
interface protocol_switcher_if #(
    parameter int W     = 14,
    parameter int N_CH  = 5,
    parameter int SEL_W = 3
);
    logic [N_CH*W-1:0] data_i;
    logic [N_CH*W-1:0] indicator_i;
    logic [W-1:0]      dc_i;
    logic [SEL_W-1:0]  protocol_i;
    logic [W-1:0]      output0_o;
    logic [W-1:0]      output1_o;
    logic [SEL_W-1:0]  active_o;
    logic              busy_o;
    logic              invalid_o;

    modport master (
        output data_i, indicator_i, dc_i, protocol_i,
        input  output0_o, output1_o, active_o, busy_o, invalid_o
    );

    modport slave (
        input  data_i, indicator_i, dc_i, protocol_i,
        output output0_o, output1_o, active_o, busy_o, invalid_o
    );
endinterface

// File: rtl/protocol_channel_mux.sv
// rtl/protocol_channel_mux.sv - combinational (data, indicator) selection by protocol code
module protocol_channel_mux
    import protocol_switcher_pkg::*;
#(
    parameter int W     = 14,
    parameter int N_CH  = 5,
    parameter int SEL_W = 3
) (
    input  logic [N_CH*W-1:0] data_i,
    input  logic [N_CH*W-1:0] indicator_i,
    input  logic [W-1:0]      dc_i,
    input  logic [SEL_W-1:0]  sel_i,
    output logic [W-1:0]      out0_o,
    output logic [W-1:0]      out1_o
);

    // Codes above N_CH select nothing and drive zero.
    always_comb begin
        out0_o = '0;
        out1_o = '0;
        if (int'(sel_i) == PROTO_DC) begin
            out0_o = dc_i;
            out1_o = dc_i;
        end else if (int'(sel_i) <= N_CH) begin
            out0_o = data_i[ch_index(int'(sel_i))*W +: W];
            out1_o = indicator_i[ch_index(int'(sel_i))*W +: W];
        end
    end

endmodule

// File: rtl/protocol_switcher.sv
// rtl/protocol_switcher.sv - glitch-safe protocol selector with DC-park guard interval
// Optional ramp-out toward the DC level during guard: define PROTOCOL_SWITCHER_RAMP_EN.
module protocol_switcher
    import protocol_switcher_pkg::*;
#(
    parameter int W            = 14,
    parameter int N_CH         = 5,
    parameter int SEL_W        = 3,
    parameter int GUARD_CYCLES = 16,
    parameter int RAMP_STEP    = 64
) (
    input  logic               clk_i,
    input  logic               rst_i,
    protocol_switcher_if.slave bus
);

`ifdef PROTOCOL_SWITCHER_RAMP_EN
    localparam bit RAMP_EN = 1'b1;
`else
    localparam bit RAMP_EN = 1'b0;
`endif

    localparam int CNT_W = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] active_q, active_d;
    logic [SEL_W-1:0] target_q, target_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     out0_q, out0_d;
    logic [W-1:0]     out1_q, out1_d;
    logic [W-1:0]     sel0, sel1;
    logic [W-1:0]     park0, park1;

    // Only the requested code is ever muxed: whenever a new channel is connected,
    // protocol_i equals the code being connected (active in RUN, target at guard expiry).
    protocol_channel_mux #(
        .W     (W),
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_mux (
        .data_i      (bus.data_i),
        .indicator_i (bus.indicator_i),
        .dc_i        (bus.dc_i),
        .sel_i       (bus.protocol_i),
        .out0_o      (sel0),
        .out1_o      (sel1)
    );

    function automatic logic [W-1:0] ramp_toward(input logic [W-1:0] cur, input logic [W-1:0] tgt);
        logic signed [W:0] diff;
        logic signed [W:0] step;
        diff = $signed({tgt[W-1], tgt}) - $signed({cur[W-1], cur});
        step = (W+1)'(RAMP_STEP);
        if (diff <= step && diff >= -step)
            return tgt;
        else if (diff > 0)
            return cur + W'(RAMP_STEP);
        else
            return cur - W'(RAMP_STEP);
    endfunction

    always_comb begin
        park0 = bus.dc_i;
        park1 = bus.dc_i;
        if (RAMP_EN) begin
            park0 = ramp_toward(out0_q, bus.dc_i);
            park1 = ramp_toward(out1_q, bus.dc_i);
        end
    end

    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        out0_d   = out0_q;
        out1_d   = out1_q;
        case (state_q)
            ST_RUN: begin
                if (bus.protocol_i == active_q) begin
                    out0_d = sel0;
                    out1_d = sel1;
                end else if (GUARD_CYCLES == 0) begin
                    active_d = bus.protocol_i;
                    out0_d   = sel0;
                    out1_d   = sel1;
                end else begin
                    target_d = bus.protocol_i;
                    cnt_d    = CNT_LOAD;
                    state_d  = ST_GUARD;
                    out0_d   = park0;
                    out1_d   = park1;
                end
            end
            ST_GUARD: begin
                // Any change of request restarts the full guard, even back to the old code.
                if (bus.protocol_i != target_q) begin
                    target_d = bus.protocol_i;
                    cnt_d    = CNT_LOAD;
                    out0_d   = park0;
                    out1_d   = park1;
                end else if (cnt_q == '0) begin
                    active_d = target_q;
                    state_d  = ST_RUN;
                    out0_d   = sel0;
                    out1_d   = sel1;
                end else begin
                    cnt_d  = cnt_q - 1'b1;
                    out0_d = park0;
                    out1_d = park1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_RUN;
            active_q <= '0;
            target_q <= '0;
            cnt_q    <= '0;
            out0_q   <= '0;
            out1_q   <= '0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
            out0_q   <= out0_d;
            out1_q   <= out1_d;
        end
    end

    assign bus.output0_o = out0_q;
    assign bus.output1_o = out1_q;
    assign bus.active_o  = active_q;
    assign bus.busy_o    = (state_q == ST_GUARD);
    assign bus.invalid_o = (int'(active_q) > N_CH);

endmodule

// File: tb/tb_protocol_switcher.sv
// tb/tb_protocol_switcher.sv - scoreboard bench for protocol_switcher (guard build and immediate-switch build)
module tb_protocol_switcher;

    localparam int W     = 14;
    localparam int N_CH  = 5;
    localparam int SEL_W = 3;

    typedef struct {
        int o0;
        int o1;
        int act;
        int busy;
        int inv;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   dcv = 100;
    exp_t sb_a[$];
    exp_t sb_b[$];

    protocol_switcher_if #(.W(W), .N_CH(N_CH), .SEL_W(SEL_W)) bus_a ();
    protocol_switcher_if #(.W(W), .N_CH(N_CH), .SEL_W(SEL_W)) bus_b ();

    protocol_switcher #(
        .W(W), .N_CH(N_CH), .SEL_W(SEL_W), .GUARD_CYCLES(16), .RAMP_STEP(64)
    ) u_dut_a (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_a)
    );

    protocol_switcher #(
        .W(W), .N_CH(N_CH), .SEL_W(SEL_W), .GUARD_CYCLES(0), .RAMP_STEP(64)
    ) u_dut_b (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_b)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_dc(input int v);
        dcv = v;
        bus_a.dc_i = W'(v);
        bus_b.dc_i = W'(v);
    endtask

    // Drive one request, push the expected post-edge outputs, then pop and compare after the edge.
    task automatic step(input string tag, input int dut, input int p,
                        input int e0, input int e1, input int act, input int busy, input int inv);
        exp_t e;
        exp_t g;
        e = '{o0: e0, o1: e1, act: act, busy: busy, inv: inv};
        if (dut == 0) begin
            bus_a.protocol_i = SEL_W'(p);
            sb_a.push_back(e);
        end else begin
            bus_b.protocol_i = SEL_W'(p);
            sb_b.push_back(e);
        end
        @(posedge clk);
        #1;
        if (dut == 0) begin
            g = sb_a.pop_front();
            check_val({tag, " out0"}, int'($signed(bus_a.output0_o)), g.o0);
            check_val({tag, " out1"}, int'($signed(bus_a.output1_o)), g.o1);
            check_val({tag, " active"}, int'(bus_a.active_o), g.act);
            check_val({tag, " busy"}, int'(bus_a.busy_o), g.busy);
            check_val({tag, " invalid"}, int'(bus_a.invalid_o), g.inv);
        end else begin
            g = sb_b.pop_front();
            check_val({tag, " out0"}, int'($signed(bus_b.output0_o)), g.o0);
            check_val({tag, " out1"}, int'($signed(bus_b.output1_o)), g.o1);
            check_val({tag, " active"}, int'(bus_b.active_o), g.act);
            check_val({tag, " busy"}, int'(bus_b.busy_o), g.busy);
            check_val({tag, " invalid"}, int'(bus_b.invalid_o), g.inv);
        end
    endtask

    task automatic park_steps(input string tag, input int p, input int n, input int act, input int inv);
        for (int j = 0; j < n; j++)
            step(tag, 0, p, dcv, dcv, act, 1, inv);
    endtask

    initial begin
        bus_a.protocol_i = '0;
        bus_b.protocol_i = '0;
        for (int c = 0; c < N_CH; c++) begin
            bus_a.data_i[c*W +: W]      = W'(1000 + c);
            bus_a.indicator_i[c*W +: W] = W'(-(200 + c));
        end
        bus_a.data_i[2*W +: W]      = W'(500);
        bus_a.indicator_i[2*W +: W] = W'(-7);
        bus_b.data_i      = bus_a.data_i;
        bus_b.indicator_i = bus_a.indicator_i;
        set_dc(100);

        // reset, then DC on the first edge after release
        step("reset0", 0, 0, 0, 0, 0, 0, 0);
        step("reset1", 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        step("release", 0, 0, 100, 100, 0, 0, 0);

        // 0 -> 3 with a 16-cycle guard; dc tracked live mid-guard
        step("g3_k", 0, 3, 100, 100, 0, 1, 0);
        for (int j = 1; j < 16; j++) begin
            if (j == 8) set_dc(-50);
            step("g3_park", 0, 3, dcv, dcv, 0, 1, 0);
        end
        step("g3_conn", 0, 3, 500, -7, 3, 0, 0);
        step("g3_hold", 0, 3, 500, -7, 3, 0, 0);
        set_dc(100);
        step("g3_dcchg", 0, 3, 500, -7, 3, 0, 0);

        // retarget to 4 five edges into a guard toward 2
        park_steps("rt_pre", 2, 5, 3, 0);
        park_steps("rt_post", 4, 16, 3, 0);
        step("rt_conn", 0, 4, 1003, -203, 4, 0, 0);

        // invalid code, then back to a valid one
        park_steps("inv_park", 7, 16, 4, 0);
        step("inv_conn", 0, 7, 0, 0, 7, 0, 1);
        step("inv_hold", 0, 7, 0, 0, 7, 0, 1);
        park_steps("inv_exit", 1, 16, 7, 1);
        step("inv_clear", 0, 1, 1000, -200, 1, 0, 0);

        // bounce to 2 and back to 1: guard restarts, no shortcut
        step("back_k", 0, 2, dcv, dcv, 1, 1, 0);
        park_steps("back_park", 1, 16, 1, 0);
        step("back_conn", 0, 1, 1000, -200, 1, 0, 0);

        // reset mid-guard aborts to reset values
        park_steps("rg_park", 3, 3, 1, 0);
        rst = 1'b1;
        step("rg_reset", 0, 3, 0, 0, 0, 0, 0);
        rst = 1'b0;
        step("rg_release", 0, 0, 100, 100, 0, 0, 0);

        // immediate-switch build
        step("g0_to3", 1, 3, 500, -7, 3, 0, 0);
        step("g0_to7", 1, 7, 0, 0, 7, 0, 1);
        step("g0_to0", 1, 0, 100, 100, 0, 0, 0);
        step("g0_to5", 1, 5, 1004, -204, 5, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
